pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the execute stage. Computes registered forwarding selects
//  (forward_ex/forward_ls for rs1/rs2) that accompany each instruction into EX.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_cmp.sv | 31 +++
 rtl/pipe_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared sequencer states, forwarding bundle and default widths.
// Imported by pipe_ctrl and pipe_hazard_cmp.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF      = 5;
  localparam int unsigned MDU_MAX_CYC_DEF = 64;
  localparam int unsigned PERF_W_DEF      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LDUSE    = 2'd1,
    ST_MDU_BUSY = 2'd2
  } state_e;

  typedef struct packed {
    logic ex_rs1;
    logic ex_rs2;
    logic ls_rs1;
    logic ls_rs2;
  } fwd_t;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp: rs-vs-rd match for one source operand against EX and LS.
// In: rs_ren_i/rs_addr_i, ex_wen_i/ex_rd_i, ls_wen_i/ls_rd_i. Out: ex_hit_o, ls_hit_o.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              rs_ren_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic              ex_wen_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ls_wen_i,
  input  logic [REG_AW-1:0] ls_rd_i,
  output logic              ex_hit_o,
  output logic              ls_hit_o
);

  logic ex_m;
  logic ls_m;

  // x0 is hardwired; a non-zero rd is required so x0 never matches
  assign ex_m = rs_ren_i & ex_wen_i & (ex_rd_i != '0)
              & (rs_addr_i == ex_rd_i);
  assign ls_m = rs_ren_i & ls_wen_i & (ls_rd_i != '0)
              & (rs_addr_i == ls_rd_i);

  // the younger producer in EX wins over LS
  assign ex_hit_o = ex_m;
  assign ls_hit_o = ls_m & ~ex_m;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: execute-stage sequencer -- registered forwarding selects, load-use
// stall, MDU start/done sequencing with watchdog, redirect flush.
// In: clock, reset (sync, high), ID operand info, EX/LS rd info, i_redirect,
// i_mdu_done. Out: o_fwd_*, o_stall_if/id/ex, o_flush_id/ex, o_mdu_start,
// o_mdu_err. Macro PIPE_CTRL_PERF_EN adds o_cnt_lduse/o_cnt_mdu/o_cnt_flush.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned MDU_MAX_CYC = MDU_MAX_CYC_DEF,
  parameter int unsigned PERF_W      = PERF_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_id_valid,
  input  logic              i_id_rs1_ren,
  input  logic              i_id_rs2_ren,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_is_mdu,
  input  logic              i_ex_rd_wen,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_mem_read,
  input  logic              i_ls_rd_wen,
  input  logic [REG_AW-1:0] i_ls_rd_addr,
  input  logic              i_redirect,
  input  logic              i_mdu_done,
  output logic              o_fwd_ex_rs1,
  output logic              o_fwd_ex_rs2,
  output logic              o_fwd_ls_rs1,
  output logic              o_fwd_ls_rs2,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_flush_id,
  output logic              o_flush_ex,
  output logic              o_mdu_start,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0] o_cnt_lduse,
  output logic [PERF_W-1:0] o_cnt_mdu,
  output logic [PERF_W-1:0] o_cnt_flush,
`endif
  output logic              o_mdu_err
);

  localparam int unsigned CNT_W = $clog2(MDU_MAX_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYC - 1);

  if (MDU_MAX_CYC < 2 || PERF_W < 1) begin : g_bad_cfg
    $error("pipe_ctrl: need MDU_MAX_CYC >= 2 and PERF_W >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  fwd_t             fwd_q, fwd_d;

  logic ex_hit1, ls_hit1;
  logic ex_hit2, ls_hit2;
  logic ld_use;

  logic stall_if, stall_id, stall_ex;
  logic flush_id, flush_ex;
  logic mdu_start;

  pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
    .rs_ren_i  (i_id_rs1_ren),
    .rs_addr_i (i_id_rs1_addr),
    .ex_wen_i  (i_ex_rd_wen),
    .ex_rd_i   (i_ex_rd_addr),
    .ls_wen_i  (i_ls_rd_wen),
    .ls_rd_i   (i_ls_rd_addr),
    .ex_hit_o  (ex_hit1),
    .ls_hit_o  (ls_hit1)
  );

  pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
    .rs_ren_i  (i_id_rs2_ren),
    .rs_addr_i (i_id_rs2_addr),
    .ex_wen_i  (i_ex_rd_wen),
    .ex_rd_i   (i_ex_rd_addr),
    .ls_wen_i  (i_ls_rd_wen),
    .ls_rd_i   (i_ls_rd_addr),
    .ex_hit_o  (ex_hit2),
    .ls_hit_o  (ls_hit2)
  );

  assign ld_use = i_id_valid & i_ex_mem_read
                & (ex_hit1 | ex_hit2);

  assign fwd_d = '{
    ex_rs1: ex_hit1,
    ex_rs2: ex_hit2,
    ls_rs1: ls_hit1,
    ls_rs2: ls_hit2
  };

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    mdu_start = 1'b0;
    unique case (state_q)
      ST_RUN, ST_LDUSE: begin
        cnt_d = '0;
        if (i_redirect) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          state_d  = ST_RUN;
        end else if (state_q == ST_RUN && ld_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          state_d  = ST_LDUSE;
        end else if (state_q == ST_RUN
                     && i_id_valid && i_id_is_mdu) begin
          state_d = ST_MDU_BUSY;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDU_BUSY: begin
        // counter is cleared on entry, so zero marks the launch cycle
        mdu_start = (cnt_q == '0);
        if (i_mdu_done) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // selects travel with the instruction entering EX
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_q <= '0;
    end else if (flush_ex) begin
      fwd_q <= '0;
    end else if (!stall_ex && !stall_id) begin
      fwd_q <= fwd_d;
    end
  end

  // the MDU owns EX while busy; a redirect then is illegal and ignored
  a_no_redirect_busy : assert property (
    @(posedge clock) disable iff (reset)
    (state_q == ST_MDU_BUSY) |-> !i_redirect
  );

  assign o_fwd_ex_rs1 = fwd_q.ex_rs1;
  assign o_fwd_ex_rs2 = fwd_q.ex_rs2;
  assign o_fwd_ls_rs1 = fwd_q.ls_rs1;
  assign o_fwd_ls_rs2 = fwd_q.ls_rs2;
  assign o_stall_if   = stall_if;
  assign o_stall_id   = stall_id;
  assign o_stall_ex   = stall_ex;
  assign o_flush_id   = flush_id;
  assign o_flush_ex   = flush_ex;
  assign o_mdu_start  = mdu_start;
  assign o_mdu_err    = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] cnt_lduse_q, cnt_mdu_q, cnt_flush_q;
  logic              inc_lduse, inc_mdu, inc_flush;

  // LDUSE is only entered from RUN, so state_d marks each entry
  assign inc_lduse = (state_d == ST_LDUSE);
  assign inc_mdu   = (state_q == ST_MDU_BUSY);
  assign inc_flush = flush_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_lduse_q <= '0;
      cnt_mdu_q   <= '0;
      cnt_flush_q <= '0;
    end else begin
      if (inc_lduse && !(&cnt_lduse_q))
        cnt_lduse_q <= cnt_lduse_q + 1'b1;
      if (inc_mdu && !(&cnt_mdu_q))
        cnt_mdu_q <= cnt_mdu_q + 1'b1;
      if (inc_flush && !(&cnt_flush_q))
        cnt_flush_q <= cnt_flush_q + 1'b1;
    end
  end

  assign o_cnt_lduse = cnt_lduse_q;
  assign o_cnt_mdu   = cnt_mdu_q;
  assign o_cnt_flush = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (default build).
// Per-cycle expected outputs are queued at drive time and popped at negedge.
module tb_pipe_ctrl;

  localparam int MAXC = 16;

  typedef struct packed {
    logic       v;
    logic       r1e;
    logic [4:0] r1;
    logic       r2e;
    logic [4:0] r2;
    logic       mdu;
    logic       exw;
    logic [4:0] exa;
    logic       ld;
    logic       lsw;
    logic [4:0] lsa;
    logic       rd;
    logic       dn;
  } stim_t;

  // {fwd ex1,ex2,ls1,ls2}_{stall if,id,ex}_{flush id,ex}_{start}_{err}
  typedef struct packed {
    logic fex1;
    logic fex2;
    logic fls1;
    logic fls2;
    logic sif;
    logic sid;
    logic sex;
    logic fid;
    logic fex;
    logic st;
    logic err;
  } obs_t;

  localparam stim_t IDLE = '0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       i_id_valid = 1'b0;
  logic       i_id_rs1_ren = 1'b0;
  logic       i_id_rs2_ren = 1'b0;
  logic [4:0] i_id_rs1_addr = '0;
  logic [4:0] i_id_rs2_addr = '0;
  logic       i_id_is_mdu = 1'b0;
  logic       i_ex_rd_wen = 1'b0;
  logic [4:0] i_ex_rd_addr = '0;
  logic       i_ex_mem_read = 1'b0;
  logic       i_ls_rd_wen = 1'b0;
  logic [4:0] i_ls_rd_addr = '0;
  logic       i_redirect = 1'b0;
  logic       i_mdu_done = 1'b0;
  logic       o_fwd_ex_rs1, o_fwd_ex_rs2;
  logic       o_fwd_ls_rs1, o_fwd_ls_rs2;
  logic       o_stall_if, o_stall_id, o_stall_ex;
  logic       o_flush_id, o_flush_ex;
  logic       o_mdu_start, o_mdu_err;

  obs_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(
    .REG_AW      (5),
    .MDU_MAX_CYC (MAXC),
    .PERF_W      (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_id_valid    (i_id_valid),
    .i_id_rs1_ren  (i_id_rs1_ren),
    .i_id_rs2_ren  (i_id_rs2_ren),
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_is_mdu   (i_id_is_mdu),
    .i_ex_rd_wen   (i_ex_rd_wen),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ls_rd_wen   (i_ls_rd_wen),
    .i_ls_rd_addr  (i_ls_rd_addr),
    .i_redirect    (i_redirect),
    .i_mdu_done    (i_mdu_done),
    .o_fwd_ex_rs1  (o_fwd_ex_rs1),
    .o_fwd_ex_rs2  (o_fwd_ex_rs2),
    .o_fwd_ls_rs1  (o_fwd_ls_rs1),
    .o_fwd_ls_rs2  (o_fwd_ls_rs2),
    .o_stall_if    (o_stall_if),
    .o_stall_id    (o_stall_id),
    .o_stall_ex    (o_stall_ex),
    .o_flush_id    (o_flush_id),
    .o_flush_ex    (o_flush_ex),
    .o_mdu_start   (o_mdu_start),
    .o_mdu_err     (o_mdu_err)
  );

  function automatic stim_t S(
    logic v, logic r1e, logic [4:0] r1,
    logic r2e, logic [4:0] r2, logic mdu,
    logic exw, logic [4:0] exa, logic ld,
    logic lsw, logic [4:0] lsa,
    logic rd, logic dn
  );
    stim_t s;
    s.v = v;     s.r1e = r1e; s.r1 = r1;
    s.r2e = r2e; s.r2 = r2;   s.mdu = mdu;
    s.exw = exw; s.exa = exa; s.ld = ld;
    s.lsw = lsw; s.lsa = lsa;
    s.rd = rd;   s.dn = dn;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    i_id_valid    = s.v;
    i_id_rs1_ren  = s.r1e;
    i_id_rs1_addr = s.r1;
    i_id_rs2_ren  = s.r2e;
    i_id_rs2_addr = s.r2;
    i_id_is_mdu   = s.mdu;
    i_ex_rd_wen   = s.exw;
    i_ex_rd_addr  = s.exa;
    i_ex_mem_read = s.ld;
    i_ls_rd_wen   = s.lsw;
    i_ls_rd_addr  = s.lsa;
    i_redirect    = s.rd;
    i_mdu_done    = s.dn;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.fex1 = o_fwd_ex_rs1;
    o.fex2 = o_fwd_ex_rs2;
    o.fls1 = o_fwd_ls_rs1;
    o.fls2 = o_fwd_ls_rs2;
    o.sif  = o_stall_if;
    o.sid  = o_stall_id;
    o.sex  = o_stall_ex;
    o.fid  = o_flush_id;
    o.fex  = o_flush_ex;
    o.st   = o_mdu_start;
    o.err  = o_mdu_err;
    return o;
  endfunction

  task automatic settle();
    repeat (2) begin
      @(posedge clock); #1;
      apply(IDLE);
    end
  endtask

  task automatic test_reset();
    obs_t got, want;
    repeat (2) @(posedge clock);
    #1;
    sb.push_back(obs_t'(11'b0));
    @(negedge clock);
    want = sb.pop_front(); got = sample(); n_tot++;
    if (got !== want)
      $display("FAIL reset_hold got=%b want=%b", got, want);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.push_back(obs_t'(11'b0));
    @(negedge clock);
    want = sb.pop_front(); got = sample(); n_tot++;
    if (got !== want)
      $display("FAIL reset_rel got=%b want=%b", got, want);
    else n_pass++;
  endtask

  task automatic test_fwd_ex();
    stim_t st[$];
    logic [10:0] ex[$];
    obs_t got, want;
    settle();
    st = {S(1,1,5,0,0,0,1,5,0,0,0,0,0), IDLE, IDLE};
    ex = {11'b0, 11'b1000_000_00_0_0, 11'b0};
    foreach (st[i]) begin
      @(posedge clock); #1;
      apply(st[i]);
      sb.push_back(obs_t'(ex[i]));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL fwd_ex[%0d] got=%b want=%b", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_fwd_prio();
    stim_t st[$];
    logic [10:0] ex[$];
    obs_t got, want;
    settle();
    st = {S(1,0,0,1,7,0,1,7,0,1,7,0,0),
          S(1,1,9,0,0,0,0,0,0,1,9,0,0),
          S(1,1,0,1,0,0,1,0,0,1,0,0,0),
          S(1,0,4,0,0,0,1,4,0,0,0,0,0),
          S(1,1,8,0,0,0,0,8,0,0,0,0,0),
          IDLE};
    ex = {11'b0,
          11'b0100_000_00_0_0,
          11'b0010_000_00_0_0,
          11'b0, 11'b0, 11'b0};
    foreach (st[i]) begin
      @(posedge clock); #1;
      apply(st[i]);
      sb.push_back(obs_t'(ex[i]));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL fwd_prio[%0d] got=%b want=%b", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [10:0] ex[$];
    obs_t got, want;
    settle();
    st = {S(1,1,3,0,0,0,1,3,1,0,0,0,0),
          S(1,1,3,0,0,0,0,0,0,1,3,0,0),
          IDLE, IDLE,
          S(1,0,0,1,6,0,1,6,1,0,0,0,0),
          S(1,0,0,1,6,0,0,0,0,1,6,0,0),
          IDLE};
    ex = {11'b0000_110_01_0_0,
          11'b0,
          11'b0010_000_00_0_0,
          11'b0,
          11'b0000_110_01_0_0,
          11'b0,
          11'b0001_000_00_0_0};
    foreach (st[i]) begin
      @(posedge clock); #1;
      apply(st[i]);
      sb.push_back(obs_t'(ex[i]));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_mdu();
    obs_t got, want;
    stim_t s;
    logic [10:0] e;
    int n_stall = 0;
    int n_start = 0;
    settle();
    // MDU issue that also forwards rs1 from EX; select must hold while busy
    @(posedge clock); #1;
    apply(S(1,1,5,0,0,1,1,5,0,0,0,0,0));
    sb.push_back(obs_t'(11'b0));
    @(negedge clock);
    want = sb.pop_front(); got = sample(); n_tot++;
    if (got !== want)
      $display("FAIL mdu_issue got=%b want=%b", got, want);
    else n_pass++;
    for (int k = 0; k <= 11; k++) begin
      s = IDLE;
      s.dn = (k == 10);
      if (k == 0)       e = 11'b1000_111_00_1_0;
      else if (k < 10)  e = 11'b1000_111_00_0_0;
      else if (k == 10) e = 11'b1000_000_00_0_0;
      else              e = 11'b0;
      @(posedge clock); #1;
      apply(s);
      sb.push_back(obs_t'(e));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got.sex) n_stall++;
      if (got.st)  n_start++;
      if (got !== want)
        $display("FAIL mdu_busy[%0d] got=%b want=%b", k, got, want);
      else n_pass++;
    end
    n_tot++;
    if (n_stall !== 10)
      $display("FAIL mdu_stall_cnt got=%0d want=10", n_stall);
    else n_pass++;
    n_tot++;
    if (n_start !== 1)
      $display("FAIL mdu_start_cnt got=%0d want=1", n_start);
    else n_pass++;
    // a done pulse in RUN must not disturb anything
    for (int k = 0; k < 2; k++) begin
      s = IDLE;
      s.dn = (k == 0);
      @(posedge clock); #1;
      apply(s);
      sb.push_back(obs_t'(11'b0));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL done_idle[%0d] got=%b want=%b", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    stim_t st[$];
    logic [10:0] ex[$];
    obs_t got, want;
    settle();
    st = {S(1,1,3,0,0,0,1,3,1,0,0,1,0),
          S(1,1,3,0,0,0,1,3,1,0,0,0,0),
          S(1,1,3,0,0,0,0,0,0,1,3,1,0),
          S(1,1,3,0,0,0,1,3,1,0,0,0,0),
          IDLE,
          S(1,0,0,0,0,1,0,0,0,0,0,1,0),
          IDLE, IDLE};
    ex = {11'b0000_000_11_0_0,
          11'b0000_110_01_0_0,
          11'b0000_000_11_0_0,
          11'b0000_110_01_0_0,
          11'b0,
          11'b0000_000_11_0_0,
          11'b0, 11'b0};
    foreach (st[i]) begin
      @(posedge clock); #1;
      apply(st[i]);
      sb.push_back(obs_t'(ex[i]));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL redirect[%0d] got=%b want=%b", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_mdu_timeout();
    obs_t got, want;
    logic [10:0] e;
    settle();
    @(posedge clock); #1;
    apply(S(1,0,0,0,0,1,0,0,0,0,0,0,0));
    sb.push_back(obs_t'(11'b0));
    @(negedge clock);
    want = sb.pop_front(); got = sample(); n_tot++;
    if (got !== want)
      $display("FAIL wdog_issue got=%b want=%b", got, want);
    else n_pass++;
    for (int k = 0; k <= MAXC + 1; k++) begin
      if (k == 0)        e = 11'b0000_111_00_1_0;
      else if (k < MAXC) e = 11'b0000_111_00_0_0;
      else               e = 11'b0000_000_00_0_1;
      @(posedge clock); #1;
      apply(IDLE);
      sb.push_back(obs_t'(e));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL wdog[%0d] got=%b want=%b", k, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_mdu();
    stim_t st[$];
    logic [10:0] ex[$];
    obs_t got, want;
    st = {S(1,0,0,0,0,1,0,0,0,0,0,0,0), IDLE, IDLE};
    ex = {11'b0000_000_00_0_1,
          11'b0000_111_00_1_1,
          11'b0000_111_00_0_1};
    foreach (st[i]) begin
      @(posedge clock); #1;
      apply(st[i]);
      sb.push_back(obs_t'(ex[i]));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL rst_mdu[%0d] got=%b want=%b", i, got, want);
      else n_pass++;
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k != 0) begin
        @(posedge clock); #1;
      end
      apply(IDLE);
      sb.push_back(obs_t'(11'b0));
      @(negedge clock);
      want = sb.pop_front(); got = sample(); n_tot++;
      if (got !== want)
        $display("FAIL rst_after[%0d] got=%b want=%b", k, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_prio();
    test_load_use();
    test_mdu();
    test_redirect();
    test_mdu_timeout();
    test_reset_in_mdu();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
